// File: rtl/mm_pkg.sv
// Shared definitions for the streaming matrix multiply/add engine:
// state encoding, operation-mode constants and default widths.
package mm_pkg;
  localparam int DEF_DW   = 8;
  localparam int DEF_MAXN = 4;
  localparam int DEF_OW   = 20;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_ADD = 1'b1;

  typedef enum logic [2:0] {
    LOAD_A, LOAD_B, CHECK, CALC, OUT, ILLEGAL, DONE
  } state_t;
endpackage

// File: rtl/mm_mac.sv
// Signed multiply-accumulate lane; in add mode it sums the sign-extended
// operands instead, so one datapath serves both matrix operations.
module mm_mac #(
  parameter int DW = 8,
  parameter int OW = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 add,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [OW-1:0] acc
);
  logic signed [2*DW-1:0] am, bm, prod;
  logic signed [OW-1:0]   ax, bx, px, term;

  assign am   = {{DW{a[DW-1]}}, a};
  assign bm   = {{DW{b[DW-1]}}, b};
  assign prod = am * bm;
  assign ax   = {{(OW-DW){a[DW-1]}}, a};
  assign bx   = {{(OW-DW){b[DW-1]}}, b};
  assign px   = {{(OW-2*DW){prod[2*DW-1]}}, prod};
  assign term = add ? (ax + bx) : px;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + term;
  end
endmodule

// File: rtl/mat_mul_gen.sv
// Loads two row-major matrices from a stream, checks shapes, then emits
// A*B (or A+B) one element at a time with a valid/ready handshake.
module mat_mul_gen
  import mm_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int MAXN = DEF_MAXN,
  parameter int OW   = DEF_OW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_data,
  input  logic                 col_end,
  input  logic                 row_end,
  input  logic                 mode,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_data,
  output logic                 valid,
  output logic                 is_legal,
  output logic                 change_row,
  output logic                 busy
);
  localparam int IW = (MAXN > 1) ? $clog2(MAXN) : 1;
  // Counters saturate at MAXN+1 so an oversized row or matrix is still seen
  // as oversized rather than wrapping back into range.
  localparam int CW = $clog2(MAXN + 3);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] MAXC = CW'(MAXN);
  localparam logic [CW-1:0] SATC = CW'(MAXN + 1);

  state_t state, state_nx;
  logic [CW-1:0] r, c, i, j, k, len, nrows, ncols;
  logic [1:0][CW-1:0] rows, cols;
  logic [1:0] bad;
  logic mode_q, op, ld, brk, legal, last_k, last_j, last_i, hs;
  logic signed [DW-1:0] mem [2][MAXN][MAXN];
  logic [IW-1:0] a_col, b_row;
  logic signed [DW-1:0] mac_a, mac_b;
  logic signed [OW-1:0] acc;

  assign op     = (state == LOAD_B);
  assign ld     = in_valid && (state == LOAD_A || state == LOAD_B);
  assign brk    = col_end || row_end;
  assign len    = c + ONE;
  assign legal  = ~|bad && ((mode_q == MODE_ADD) ? (rows[0] == rows[1] && cols[0] == cols[1])
                                                 : (cols[0] == rows[1]));
  assign nrows  = rows[0];
  assign ncols  = (mode_q == MODE_ADD) ? cols[0] : cols[1];
  assign last_k = (mode_q == MODE_ADD) || (k == cols[0] - ONE);
  assign last_j = (j == ncols - ONE);
  assign last_i = (i == nrows - ONE);
  assign hs     = (state == OUT) && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD_A;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD_A:  if (in_valid && row_end) state_nx = LOAD_B;
      LOAD_B:  if (in_valid && row_end) state_nx = CHECK;
      CHECK:   state_nx = legal ? CALC : ILLEGAL;
      CALC:    if (last_k) state_nx = OUT;
      OUT:     if (out_ready) state_nx = (last_i && last_j) ? DONE : CALC;
      ILLEGAL: if (out_ready) state_nx = DONE;
      DONE:    state_nx = LOAD_A;
      default: state_nx = LOAD_A;
    endcase
  end

  always_comb begin
    valid      = 1'b0;
    is_legal   = 1'b0;
    change_row = 1'b0;
    out_data   = '0;
    busy       = 1'b1;
    case (state)
      LOAD_A, LOAD_B, DONE: busy = 1'b0;
      OUT: begin
        valid      = 1'b1;
        is_legal   = 1'b1;
        change_row = last_j;
        out_data   = acc;
      end
      ILLEGAL: valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r <= '0; c <= '0; i <= '0; j <= '0; k <= '0;
      rows <= '0; cols <= '0; bad <= '0; mode_q <= MODE_MUL;
    end else begin
      case (state)
        LOAD_A, LOAD_B: if (in_valid) begin
          if (!op && r == '0 && c == '0) mode_q <= mode;
          if (brk) begin
            c <= '0;
            if (r == '0) cols[op] <= len;
            if (len > MAXC || (r != '0 && len != cols[op])) bad[op] <= 1'b1;
            if (row_end) begin
              r        <= '0;
              rows[op] <= r + ONE;
              if (r >= MAXC) bad[op] <= 1'b1;
            end else if (r < SATC) begin
              r <= r + ONE;
            end
          end else if (c < SATC) begin
            c <= len;
          end
        end
        CALC: k <= last_k ? '0 : k + ONE;
        OUT: if (out_ready) begin
          if (last_j) begin
            j <= '0;
            i <= i + ONE;
          end else begin
            j <= j + ONE;
          end
        end
        DONE: begin
          r <= '0; c <= '0; i <= '0; j <= '0; k <= '0;
          rows <= '0; cols <= '0; bad <= '0; mode_q <= MODE_MUL;
        end
        default: ;
      endcase
    end
  end

  // Elements past MAXN in either direction are dropped, never wrapped.
  always_ff @(posedge clk) begin
    if (ld && r < MAXC && c < MAXC) mem[op][r[IW-1:0]][c[IW-1:0]] <= in_data;
  end

  assign a_col = (mode_q == MODE_ADD) ? j[IW-1:0] : k[IW-1:0];
  assign b_row = (mode_q == MODE_ADD) ? i[IW-1:0] : k[IW-1:0];
  assign mac_a = mem[0][i[IW-1:0]][a_col];
  assign mac_b = mem[1][b_row][j[IW-1:0]];

  mm_mac #(.DW(DW), .OW(OW)) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (state == CHECK || hs),
    .en  (state == CALC),
    .add (mode_q),
    .a   (mac_a),
    .b   (mac_b),
    .acc (acc)
  );
endmodule
